memory_stage_ws: RTL and testbench
==================================

MEMORY_STAGE_WS -- requirements
Module: memory_stage_ws

Interface
REQ-001 Parameter WORD_W, default 64: data word width in bits; valA, valE and valM are all WORD_W wide.
REQ-002 Parameter ADDR_W, default 7: word-index bits; memory depth is 2**ADDR_W words.
REQ-003 Parameter LATENCY, default 1, legal range 1..8: cycles per memory access.
REQ-004 clk  in  1  single clock; all state updates on posedge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 M_icode  in  4  instruction code from the M register.
REQ-007 M_stat  in  4  status from the M register: AOK=1, HLT=2, ADR=3, INS=4.
REQ-008 M_valA, M_valE  in  WORD_W  store data / pop-ret address; computed address.
REQ-009 M_dstE, M_dstM  in  4  destination register IDs.
REQ-010 m_icode, m_dstE, m_dstM  out  4  pass-through of M_icode, M_dstE, M_dstM.
REQ-011 m_valE  out  WORD_W  pass-through of M_valE.
REQ-012 m_valM  out  WORD_W  read data.
REQ-013 m_stat  out  4  resolved status.
REQ-014 m_stall  out  1  high while an access is incomplete; upstream holds all M_* inputs stable while it is high.

Function
REQ-015 Reads SHALL be mrmovq (5) at M_valE, and ret (9) and popq (B) at M_valA; writes SHALL be rmmovq (4), call (8) and pushq (A), storing M_valA at M_valE.
REQ-016 Addresses SHALL be byte addresses; word index = addr[ADDR_W+2:3]; addr[2:0] SHALL be ignored.
REQ-017 An access SHALL occupy LATENCY cycles, tracked by counter cnt (width clog2(8)): m_stall = mem_op && (cnt != LATENCY-1); cnt increments on posedge while m_stall is high and clears to 0 otherwise.
REQ-018 m_valM SHALL be valid, combinationally from the array, only in the final access cycle; it SHALL be 0 in every other cycle and for non-read icodes.
REQ-019 A write SHALL commit only at the posedge ending the final access cycle, exactly once per instruction.
REQ-020 A write SHALL be suppressed when M_stat != AOK; m_stat then equals M_stat.
REQ-021 With LATENCY=1, m_stall SHALL be constantly 0 and the block is single-cycle.
REQ-022 Non-memory icodes SHALL pass through in one cycle with m_stall=0 and cnt held at 0.
REQ-023 A read of a word written in the same final cycle SHALL return the old contents.

Reset
REQ-024 While rst is high: cnt=0, m_stall=0, m_valM=0, no write; pass-through outputs still follow their inputs.
REQ-025 Reset asserted mid-access SHALL abort the access: no write, and cnt=0 on the next cycle.
REQ-026 Memory contents SHALL NOT be cleared by reset.

Configuration
REQ-027 Macro DMEM_BOUNDS_CHECK_EN defined: a mem_op whose addr >= 8*2**ADDR_W SHALL give m_stat=ADR (3) in its final cycle, suppress the write, and give m_valM=0.
REQ-028 Macro undefined: the upper address bits SHALL be ignored, addresses wrap modulo the depth, and m_stat=M_stat always.

Structure
REQ-029 A shared package SHALL hold the Y86 icode constants (IRMMOVQ, IMRMOVQ, ICALL, IRET, IPUSHQ, IPOPQ) and the status constants (SAOK, SHLT, SADR, SINS).
REQ-030 One sub-module, dmem_array (synchronous write, asynchronous read, parameterised WORD_W and ADDR_W), SHALL hold the storage; the counter and control logic SHALL stay in memory_stage_ws.

Verification
REQ-031 LATENCY=1: rmmovq with valE=0x10, valA=0xDEAD, then mrmovq with valE=0x10 -> m_valM=0xDEAD in the read cycle, m_stall=0 throughout.
REQ-032 LATENCY=3: pushq with valE=0x20, valA=0x55 -> m_stall high for 2 cycles, write committed at the 3rd posedge; a following popq with valA=0x20 -> m_valM=0x55 in its 3rd cycle.
REQ-033 LATENCY=4: rst pulsed in cycle 2 of rmmovq to 0x08 -> word 1 unchanged, cnt=0, m_stall=0 the cycle after rst.
REQ-034 M_stat=HLT with rmmovq to 0x18 -> word 3 unchanged, m_stat=2.
REQ-035 DMEM_BOUNDS_CHECK_EN defined, ADDR_W=7: mrmovq with valE=0x400 -> m_stat=3, m_valM=0; macro undefined: same stimulus reads word 0.
REQ-036 LATENCY=2: opq (icode 6) between two memory ops -> opq passes through in 1 cycle, m_stall=0.

Source files
------------

// File: rtl/memory_stage_ws_pkg.sv
// Shared Y86 constants for the memory stage: instruction codes, status codes,
// and helpers that classify an icode as a data-memory read or write.
package memory_stage_ws_pkg;

    localparam logic [3:0] IRMMOVQ = 4'h4;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] ICALL   = 4'h8;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPUSHQ  = 4'hA;
    localparam logic [3:0] IPOPQ   = 4'hB;

    localparam logic [3:0] SAOK = 4'h1;
    localparam logic [3:0] SHLT = 4'h2;
    localparam logic [3:0] SADR = 4'h3;
    localparam logic [3:0] SINS = 4'h4;

    // Wide enough for the largest legal access latency of 8 cycles.
    localparam int CNT_W = 3;

    function automatic logic isMemRead(input logic [3:0] icode);
        return (icode == IMRMOVQ) || (icode == IRET) || (icode == IPOPQ);
    endfunction

    function automatic logic isMemWrite(input logic [3:0] icode);
        return (icode == IRMMOVQ) || (icode == ICALL) || (icode == IPUSHQ);
    endfunction

endpackage

// File: rtl/memory_stage_ws_dmem_array.sv
// Data memory storage for the memory stage: synchronous write, asynchronous
// read, contents deliberately left untouched by reset.
module dmem_array
    import memory_stage_ws_pkg::*;
#(
    parameter int WORD_W = 64,
    parameter int ADDR_W = 7
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [WORD_W-1:0] wdata_i,
    output logic [WORD_W-1:0] rdata_o
);

    logic [WORD_W-1:0] mem_q [2**ADDR_W];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    // A read in the commit cycle sees the old word; the new one lands at the edge.
    assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/memory_stage_ws.sv
// Y86 memory stage with a multi-cycle data memory access (LATENCY cycles).
// Optional macro DMEM_BOUNDS_CHECK_EN flags out-of-range addresses as ADR.
module memory_stage_ws
    import memory_stage_ws_pkg::*;
#(
    parameter int WORD_W  = 64,
    parameter int ADDR_W  = 7,
    parameter int LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        M_icode,
    input  logic [3:0]        M_stat,
    input  logic [WORD_W-1:0] M_valA,
    input  logic [WORD_W-1:0] M_valE,
    input  logic [3:0]        M_dstE,
    input  logic [3:0]        M_dstM,
    output logic [3:0]        m_icode,
    output logic [3:0]        m_dstE,
    output logic [3:0]        m_dstM,
    output logic [WORD_W-1:0] m_valE,
    output logic [WORD_W-1:0] m_valM,
    output logic [3:0]        m_stat,
    output logic              m_stall
);

    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              memRead, memWrite, memOp, lastCycle;
    logic              addrBad, writeEn;
    logic [WORD_W-1:0] addr, rdData;
    logic              unusedAddrBits;

    assign m_icode = M_icode;
    assign m_dstE  = M_dstE;
    assign m_dstM  = M_dstM;
    assign m_valE  = M_valE;

    assign memRead  = isMemRead(M_icode);
    assign memWrite = isMemWrite(M_icode);
    assign addr     = ((M_icode == IRET) || (M_icode == IPOPQ)) ? M_valA : M_valE;

    // Reset masks the access entirely so an in-flight operation is abandoned.
    assign memOp     = (memRead || memWrite) && !rst;
    assign lastCycle = memOp && (cnt_q == CNT_W'(LATENCY - 1));
    assign m_stall   = memOp && !lastCycle;
    assign cnt_d     = m_stall ? (cnt_q + CNT_W'(1)) : '0;

`ifdef DMEM_BOUNDS_CHECK_EN
    assign addrBad        = |addr[WORD_W-1:ADDR_W+3];
    assign unusedAddrBits = ^addr[2:0];
`else
    assign addrBad        = 1'b0;
    assign unusedAddrBits = ^{addr[WORD_W-1:ADDR_W+3], addr[2:0]};
`endif

    assign writeEn = memWrite && lastCycle && (M_stat == SAOK) && !addrBad;
    assign m_valM  = (memRead && lastCycle && !addrBad) ? rdData : '0;
    assign m_stat  = (lastCycle && addrBad) ? SADR : M_stat;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    dmem_array #(
        .WORD_W (WORD_W),
        .ADDR_W (ADDR_W)
    ) u_dmem (
        .clk_i   (clk),
        .we_i    (writeEn),
        .addr_i  (addr[ADDR_W+2:3]),
        .wdata_i (M_valA),
        .rdata_o (rdData)
    );

endmodule

// File: tb/tb_memory_stage_ws.sv
// Scoreboard bench for memory_stage_ws: lane 0 runs LATENCY=1, lane 1 LATENCY=3.
module tb_memory_stage_ws;
    import memory_stage_ws_pkg::*;

    localparam int WORD_W = 64;
    localparam int ADDR_W = 7;
    localparam int LAT0   = 1;
    localparam int LAT1   = 3;
    localparam logic [3:0] INOP = 4'h1;
    localparam logic [3:0] IOPQ = 4'h6;

    typedef struct {
        logic [3:0]        icode;
        logic [3:0]        stat;
        logic [3:0]        dstE;
        logic [3:0]        dstM;
        logic [WORD_W-1:0] valE;
        logic [WORD_W-1:0] valM;
        int                stalls;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst    [2];
    logic [3:0]        mIcode [2];
    logic [3:0]        mStat  [2];
    logic [3:0]        mDstE  [2];
    logic [3:0]        mDstM  [2];
    logic [WORD_W-1:0] mValA  [2];
    logic [WORD_W-1:0] mValE  [2];
    logic [3:0]        oIcode [2];
    logic [3:0]        oDstE  [2];
    logic [3:0]        oDstM  [2];
    logic [3:0]        oStat  [2];
    logic [WORD_W-1:0] oValE  [2];
    logic [WORD_W-1:0] oValM  [2];
    logic              oStall [2];

    logic [WORD_W-1:0] model [2][2**ADDR_W];
    exp_t sb[$];
    int assertions = 0;
    int failures   = 0;

    memory_stage_ws #(.WORD_W(WORD_W), .ADDR_W(ADDR_W), .LATENCY(LAT0)) dut0 (
        .clk(clk), .rst(rst[0]), .M_icode(mIcode[0]), .M_stat(mStat[0]),
        .M_valA(mValA[0]), .M_valE(mValE[0]), .M_dstE(mDstE[0]), .M_dstM(mDstM[0]),
        .m_icode(oIcode[0]), .m_dstE(oDstE[0]), .m_dstM(oDstM[0]), .m_valE(oValE[0]),
        .m_valM(oValM[0]), .m_stat(oStat[0]), .m_stall(oStall[0])
    );

    memory_stage_ws #(.WORD_W(WORD_W), .ADDR_W(ADDR_W), .LATENCY(LAT1)) dut1 (
        .clk(clk), .rst(rst[1]), .M_icode(mIcode[1]), .M_stat(mStat[1]),
        .M_valA(mValA[1]), .M_valE(mValE[1]), .M_dstE(mDstE[1]), .M_dstM(mDstM[1]),
        .m_icode(oIcode[1]), .m_dstE(oDstE[1]), .m_dstM(oDstM[1]), .m_valE(oValE[1]),
        .m_valM(oValM[1]), .m_stat(oStat[1]), .m_stall(oStall[1])
    );

    function automatic int latOf(input int lane);
        return (lane == 0) ? LAT0 : LAT1;
    endfunction

    // Drives one instruction on a lane, pushes its expectation, and compares
    // when the lane reports its final (non-stalled) cycle.
    task automatic applyStimulus(input int lane, input logic [3:0] icode, input logic [3:0] stat,
                                 input logic [WORD_W-1:0] valA, input logic [WORD_W-1:0] valE);
        exp_t e;
        logic rd, wr, bad;
        logic [WORD_W-1:0] a;
        int idx, stalls;
        bit done;
        rd  = (icode == IMRMOVQ) || (icode == IRET) || (icode == IPOPQ);
        wr  = (icode == IRMMOVQ) || (icode == ICALL) || (icode == IPUSHQ);
        a   = ((icode == IRET) || (icode == IPOPQ)) ? valA : valE;
        idx = int'(a[ADDR_W+2:3]);
`ifdef DMEM_BOUNDS_CHECK_EN
        bad = (rd || wr) && (a >= WORD_W'(8 * 2**ADDR_W));
`else
        bad = 1'b0;
`endif
        e.icode  = icode;
        e.stat   = bad ? SADR : stat;
        e.dstE   = icode ^ 4'h3;
        e.dstM   = ~icode;
        e.valE   = valE;
        e.valM   = (rd && !bad) ? model[lane][idx] : '0;
        e.stalls = (rd || wr) ? latOf(lane) - 1 : 0;
        sb.push_back(e);

        mIcode[lane] = icode;
        mStat[lane]  = stat;
        mValA[lane]  = valA;
        mValE[lane]  = valE;
        mDstE[lane]  = icode ^ 4'h3;
        mDstM[lane]  = ~icode;

        stalls = 0;
        done   = 1'b0;
        for (int c = 0; c < 20 && !done; c++) begin
            @(negedge clk);
            if (oStall[lane]) begin
                stalls++;
                assertions++;
                if (oValM[lane] !== '0) begin
                    failures++;
                    $display("[TB] FAIL stall_valM lane%0d: got %h, required 0", lane, oValM[lane]);
                end
                @(posedge clk);
                #1;
            end else begin
                done = 1'b1;
            end
        end

        e = sb.pop_front();
        assertions++;
        if (!done) begin
            failures++;
            $display("[TB] FAIL timeout lane%0d: stall never dropped, required %0d stall cycles", lane, e.stalls);
        end else begin
            if (stalls !== e.stalls) begin
                failures++;
                $display("[TB] FAIL stall_cycles lane%0d icode %h: got %0d, required %0d", lane, icode, stalls, e.stalls);
            end
            assertions++;
            if (oValM[lane] !== e.valM) begin
                failures++;
                $display("[TB] FAIL valM lane%0d icode %h: got %h, required %h", lane, icode, oValM[lane], e.valM);
            end
            assertions++;
            if (oStat[lane] !== e.stat) begin
                failures++;
                $display("[TB] FAIL stat lane%0d icode %h: got %0d, required %0d", lane, icode, oStat[lane], e.stat);
            end
            assertions++;
            if ({oIcode[lane], oDstE[lane], oDstM[lane], oValE[lane]} !== {e.icode, e.dstE, e.dstM, e.valE}) begin
                failures++;
                $display("[TB] FAIL passthrough lane%0d: got %h/%h/%h/%h, required %h/%h/%h/%h", lane,
                         oIcode[lane], oDstE[lane], oDstM[lane], oValE[lane], e.icode, e.dstE, e.dstM, e.valE);
            end
        end

        if (wr && (stat == SAOK) && !bad) model[lane][idx] = valA;
        @(posedge clk);
        #1;
        mIcode[lane] = INOP;
    endtask

    task automatic test_reset();
        for (int l = 0; l < 2; l++) begin
            rst[l] = 1'b1; mIcode[l] = IMRMOVQ; mStat[l] = SAOK;
            mValA[l] = '0; mValE[l] = 64'h10; mDstE[l] = 4'hF; mDstM[l] = 4'h2;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int l = 0; l < 2; l++) begin
            assertions++;
            if ({oStall[l], oValM[l]} !== {1'b0, 64'h0}) begin
                failures++;
                $display("[TB] FAIL reset_outputs lane%0d: got stall=%b valM=%h, required 0/0", l, oStall[l], oValM[l]);
            end
            assertions++;
            if ({oIcode[l], oValE[l], oDstM[l]} !== {IMRMOVQ, 64'h10, 4'h2}) begin
                failures++;
                $display("[TB] FAIL reset_passthrough lane%0d: got %h/%h/%h, required 5/10/2", l, oIcode[l], oValE[l], oDstM[l]);
            end
        end
        @(posedge clk);
        #1;
        for (int l = 0; l < 2; l++) begin
            rst[l] = 1'b0; mIcode[l] = INOP;
        end
    endtask

    task automatic test_single_cycle();
        applyStimulus(0, IRMMOVQ, SAOK, 64'hDEAD, 64'h10);
        applyStimulus(0, IMRMOVQ, SAOK, 64'h0, 64'h10);
        applyStimulus(0, IMRMOVQ, SAOK, 64'h0, 64'h17);
    endtask

    task automatic test_multi_cycle();
        applyStimulus(1, IPUSHQ, SAOK, 64'h55, 64'h20);
        applyStimulus(1, IPOPQ, SAOK, 64'h20, 64'h28);
        applyStimulus(1, ICALL, SAOK, 64'h77, 64'h100);
        applyStimulus(1, IRET, SAOK, 64'h100, 64'h108);
    endtask

    task automatic test_reset_abort();
        applyStimulus(1, IRMMOVQ, SAOK, 64'h1111, 64'h08);
        mIcode[1] = IRMMOVQ; mStat[1] = SAOK; mValA[1] = 64'h2222; mValE[1] = 64'h08;
        @(posedge clk);
        #1;
        rst[1] = 1'b1;
        @(negedge clk);
        assertions++;
        if ({oStall[1], oValM[1]} !== {1'b0, 64'h0}) begin
            failures++;
            $display("[TB] FAIL abort_in_reset: got stall=%b valM=%h, required 0/0", oStall[1], oValM[1]);
        end
        @(posedge clk);
        #1;
        rst[1] = 1'b0;
        mIcode[1] = INOP;
        @(negedge clk);
        assertions++;
        if (oStall[1] !== 1'b0) begin
            failures++;
            $display("[TB] FAIL abort_after_reset: got stall=%b, required 0", oStall[1]);
        end
        @(posedge clk);
        #1;
        applyStimulus(1, IMRMOVQ, SAOK, 64'h0, 64'h08);
    endtask

    task automatic test_status();
        applyStimulus(0, IRMMOVQ, SAOK, 64'h3333, 64'h18);
        applyStimulus(0, IRMMOVQ, SHLT, 64'h4444, 64'h18);
        applyStimulus(0, IMRMOVQ, SAOK, 64'h0, 64'h18);
        applyStimulus(1, IRMMOVQ, SINS, 64'h4444, 64'h20);
        applyStimulus(1, IMRMOVQ, SAOK, 64'h0, 64'h20);
    endtask

    task automatic test_bounds();
        applyStimulus(0, IRMMOVQ, SAOK, 64'hABCD, 64'h0);
        applyStimulus(0, IMRMOVQ, SAOK, 64'h0, 64'h400);
        applyStimulus(0, IRMMOVQ, SAOK, 64'h9999, 64'h400);
        applyStimulus(0, IMRMOVQ, SAOK, 64'h0, 64'h0);
    endtask

    task automatic test_passthrough_opq();
        applyStimulus(1, IRMMOVQ, SAOK, 64'hCAFE, 64'h30);
        applyStimulus(1, IOPQ, SAOK, 64'h1, 64'h2);
        applyStimulus(1, IMRMOVQ, SAOK, 64'h0, 64'h30);
    endtask

    task automatic test_back_to_back();
        logic [WORD_W-1:0] v;
        for (int i = 0; i < 6; i++) begin
            v = {$urandom, $urandom};
            applyStimulus(0, IRMMOVQ, SAOK, v, WORD_W'((i + 40) * 8));
            applyStimulus(1, IPUSHQ, SAOK, ~v, WORD_W'((i + 50) * 8));
        end
        for (int i = 0; i < 6; i++) begin
            applyStimulus(0, IMRMOVQ, SAOK, 64'h0, WORD_W'((i + 40) * 8));
            applyStimulus(1, IPOPQ, SAOK, WORD_W'((i + 50) * 8), 64'h0);
        end
    endtask

    initial begin
        for (int l = 0; l < 2; l++) begin
            rst[l] = 1'b1; mIcode[l] = INOP; mStat[l] = SAOK;
            mValA[l] = '0; mValE[l] = '0; mDstE[l] = '0; mDstM[l] = '0;
        end
        test_reset();
        test_single_cycle();
        test_multi_cycle();
        test_reset_abort();
        test_status();
        test_bounds();
        test_passthrough_opq();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
